// File: rtl/bus_endpoint.sv
// Bus endpoint: a show-ahead TX FIFO toward the bus arbiter and an address-filtered
// show-ahead RX FIFO toward the local consumer, with sticky error flags and drop/miss counters.
module bus_endpoint #(
    parameter int unsigned pckg_sz   = 16,
    parameter int unsigned depth     = 8,
    parameter logic [7:0]  id        = 8'h00,
    parameter logic [7:0]  broadcast = {8{1'b1}}
) (
    input  logic               clk,
    input  logic               reset,
    // Local transmit side
    input  logic               wr_en,
    input  logic [pckg_sz-1:0] wr_data,
    output logic               tx_full,
    // Arbiter side of the TX FIFO
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    // Bus delivery into the RX FIFO
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    // Local receive side
    output logic               rx_valid,
    output logic [pckg_sz-1:0] rd_data,
    input  logic               rd_en,
    // Status
    output logic               tx_ovf,
    output logic               tx_udf,
    output logic [7:0]         rx_drop_cnt,
    output logic [7:0]         rx_miss_cnt
);

    localparam int unsigned AW = $clog2(depth);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] PtrInc = {{AW{1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [pckg_sz-1:0] tx_mem_q [depth];
    logic [pckg_sz-1:0] rx_mem_q [depth];

    logic [PW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
    logic [PW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
    logic [PW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
    logic [PW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;

    logic          tx_ovf_q, tx_ovf_d;
    logic          tx_udf_q, tx_udf_d;
    logic [7:0]    rx_drop_cnt_q, rx_drop_cnt_d;
    logic [7:0]    rx_miss_cnt_q, rx_miss_cnt_d;

    // ------------------------------------------------------------------
    // Occupancy decode: equal index bits with differing MSB means full
    // ------------------------------------------------------------------
    logic tx_empty, tx_full_w;
    logic rx_empty, rx_full;

    assign tx_empty  = (tx_wr_ptr_q == tx_rd_ptr_q);
    assign tx_full_w = (tx_wr_ptr_q[AW] != tx_rd_ptr_q[AW]) &&
                       (tx_wr_ptr_q[AW-1:0] == tx_rd_ptr_q[AW-1:0]);
    assign rx_empty  = (rx_wr_ptr_q == rx_rd_ptr_q);
    assign rx_full   = (rx_wr_ptr_q[AW] != rx_rd_ptr_q[AW]) &&
                       (rx_wr_ptr_q[AW-1:0] == rx_rd_ptr_q[AW-1:0]);

    // ------------------------------------------------------------------
    // Transfer qualification
    // ------------------------------------------------------------------
    logic       tx_we, tx_re;
    logic       rx_we, rx_re;
    logic       rx_match, rx_miss, rx_drop;
    logic [7:0] rx_dest;

    // A write while full is dropped even if the same edge frees a slot.
    assign tx_we    = wr_en && !tx_full_w;
    assign tx_re    = pop && !tx_empty;

    assign rx_dest  = D_push[pckg_sz-1 -: 8];
    assign rx_match = (rx_dest == id) || (rx_dest == broadcast);
    assign rx_re    = rd_en && !rx_empty;
    // A full RX FIFO is never empty, so a concurrent read always frees the slot.
    assign rx_we    = push && rx_match && (!rx_full || rx_re);
    assign rx_drop  = push && rx_match && rx_full && !rx_re;
    assign rx_miss  = push && !rx_match;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        tx_wr_ptr_d   = tx_wr_ptr_q;
        tx_rd_ptr_d   = tx_rd_ptr_q;
        rx_wr_ptr_d   = rx_wr_ptr_q;
        rx_rd_ptr_d   = rx_rd_ptr_q;
        tx_ovf_d      = tx_ovf_q;
        tx_udf_d      = tx_udf_q;
        rx_drop_cnt_d = rx_drop_cnt_q;
        rx_miss_cnt_d = rx_miss_cnt_q;

        if (tx_we) tx_wr_ptr_d = tx_wr_ptr_q + PtrInc;
        if (tx_re) tx_rd_ptr_d = tx_rd_ptr_q + PtrInc;
        if (rx_we) rx_wr_ptr_d = rx_wr_ptr_q + PtrInc;
        if (rx_re) rx_rd_ptr_d = rx_rd_ptr_q + PtrInc;

        if (wr_en && tx_full_w) tx_ovf_d = 1'b1;
        if (pop && tx_empty)    tx_udf_d = 1'b1;

        if (rx_drop && (rx_drop_cnt_q != 8'hFF)) rx_drop_cnt_d = rx_drop_cnt_q + 8'd1;
        if (rx_miss && (rx_miss_cnt_q != 8'hFF)) rx_miss_cnt_d = rx_miss_cnt_q + 8'd1;
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wr_ptr_q   <= '0;
            tx_rd_ptr_q   <= '0;
            rx_wr_ptr_q   <= '0;
            rx_rd_ptr_q   <= '0;
            tx_ovf_q      <= 1'b0;
            tx_udf_q      <= 1'b0;
            rx_drop_cnt_q <= 8'd0;
            rx_miss_cnt_q <= 8'd0;
        end else begin
            tx_wr_ptr_q   <= tx_wr_ptr_d;
            tx_rd_ptr_q   <= tx_rd_ptr_d;
            rx_wr_ptr_q   <= rx_wr_ptr_d;
            rx_rd_ptr_q   <= rx_rd_ptr_d;
            tx_ovf_q      <= tx_ovf_d;
            tx_udf_q      <= tx_udf_d;
            rx_drop_cnt_q <= rx_drop_cnt_d;
            rx_miss_cnt_q <= rx_miss_cnt_d;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (reset && tx_we) tx_mem_q[tx_wr_ptr_q[AW-1:0]] <= wr_data;
        if (reset && rx_we) rx_mem_q[rx_wr_ptr_q[AW-1:0]] <= D_push;
    end

    // ------------------------------------------------------------------
    // Outputs: show-ahead heads straight from storage
    // ------------------------------------------------------------------
    assign tx_full     = tx_full_w;
    assign pndng       = !tx_empty;
    assign D_pop       = tx_mem_q[tx_rd_ptr_q[AW-1:0]];
    assign rx_valid    = !rx_empty;
    assign rd_data     = rx_mem_q[rx_rd_ptr_q[AW-1:0]];
    assign tx_ovf      = tx_ovf_q;
    assign tx_udf      = tx_udf_q;
    assign rx_drop_cnt = rx_drop_cnt_q;
    assign rx_miss_cnt = rx_miss_cnt_q;

endmodule

// File: tb/tb_bus_endpoint.sv
// Bench for bus_endpoint: vector table, directed corner sequences and a randomized run
// checked against a queue-based model of the endpoint.
module tb_bus_endpoint;

    localparam int unsigned PSZ   = 16;
    localparam int unsigned DEPTH = 8;
    localparam logic [7:0]  MYID  = 8'h02;
    localparam logic [7:0]  BCAST = 8'hFF;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            wr_en = 1'b0;
    logic [PSZ-1:0]  wr_data = '0;
    logic            tx_full;
    logic            pndng;
    logic [PSZ-1:0]  D_pop;
    logic            pop = 1'b0;
    logic            push = 1'b0;
    logic [PSZ-1:0]  D_push = '0;
    logic            rx_valid;
    logic [PSZ-1:0]  rd_data;
    logic            rd_en = 1'b0;
    logic            tx_ovf;
    logic            tx_udf;
    logic [7:0]      rx_drop_cnt;
    logic [7:0]      rx_miss_cnt;

    bus_endpoint #(
        .pckg_sz  (PSZ),
        .depth    (DEPTH),
        .id       (MYID),
        .broadcast(BCAST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .tx_full    (tx_full),
        .pndng      (pndng),
        .D_pop      (D_pop),
        .pop        (pop),
        .push       (push),
        .D_push     (D_push),
        .rx_valid   (rx_valid),
        .rd_data    (rd_data),
        .rd_en      (rd_en),
        .tx_ovf     (tx_ovf),
        .tx_udf     (tx_udf),
        .rx_drop_cnt(rx_drop_cnt),
        .rx_miss_cnt(rx_miss_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain queues and counters
    logic [PSZ-1:0] m_tx[$];
    logic [PSZ-1:0] m_rx[$];
    bit             m_ovf, m_udf;
    int             m_drop, m_miss;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_tx.delete();
        m_rx.delete();
        m_ovf  = 0;
        m_udf  = 0;
        m_drop = 0;
        m_miss = 0;
    endtask

    task automatic model_step(input logic we, input logic [PSZ-1:0] wd, input logic p,
                              input logic ps, input logic [PSZ-1:0] dp, input logic re);
        int  txn = m_tx.size();
        int  rxn = m_rx.size();
        bit  match = (dp[PSZ-1 -: 8] == MYID) || (dp[PSZ-1 -: 8] == BCAST);
        if (p) begin
            if (txn > 0) void'(m_tx.pop_front());
            else         m_udf = 1;
        end
        if (we) begin
            if (txn == DEPTH) m_ovf = 1;
            else              m_tx.push_back(wd);
        end
        if (re && rxn > 0) void'(m_rx.pop_front());
        if (ps) begin
            if (!match) begin
                if (m_miss < 255) m_miss++;
            end else if (rxn < DEPTH || re) begin
                m_rx.push_back(dp);
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
    endtask

    task automatic model_check();
        chk("pndng", 32'(pndng), 32'(m_tx.size() != 0));
        chk("tx_full", 32'(tx_full), 32'(m_tx.size() == DEPTH));
        if (m_tx.size() != 0) chk("D_pop", 32'(D_pop), 32'(m_tx[0]));
        chk("rx_valid", 32'(rx_valid), 32'(m_rx.size() != 0));
        if (m_rx.size() != 0) chk("rd_data", 32'(rd_data), 32'(m_rx[0]));
        chk("tx_ovf", 32'(tx_ovf), 32'(m_ovf));
        chk("tx_udf", 32'(tx_udf), 32'(m_udf));
        chk("rx_drop_cnt", 32'(rx_drop_cnt), 32'(m_drop));
        chk("rx_miss_cnt", 32'(rx_miss_cnt), 32'(m_miss));
    endtask

    // Drive one cycle of inputs, advance one edge, then compare against the model.
    task automatic step(input logic we, input logic [PSZ-1:0] wd, input logic p,
                        input logic ps, input logic [PSZ-1:0] dp, input logic re);
        wr_en = we; wr_data = wd; pop = p; push = ps; D_push = dp; rd_en = re;
        @(posedge clk);
        if (reset) model_step(we, wd, p, ps, dp, re);
        #1;
        model_check();
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_clear();
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        reset = 1'b1;
    endtask

    typedef struct packed {
        logic           we;
        logic [PSZ-1:0] wd;
        logic           p;
        logic           ps;
        logic [PSZ-1:0] dp;
        logic           re;
        logic           e_pndng;
        logic [PSZ-1:0] e_dpop;
        logic           e_rxv;
        logic [PSZ-1:0] e_rd;
        logic [7:0]     e_miss;
        logic           e_udf;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    initial begin
        //            we  wd        pop ps  dp        re   pndng dpop      rxv rd        miss udf
        vecs[0]  = '{1'b1, 16'h02AA, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h02AA, 1'b0, 16'h0000, 8'd0, 1'b0};
        vecs[1]  = '{1'b1, 16'h0355, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h02AA, 1'b0, 16'h0000, 8'd0, 1'b0};
        vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0355, 1'b0, 16'h0000, 8'd0, 1'b0};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'd0, 1'b0};
        vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0211, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0211, 8'd0, 1'b0};
        vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0311, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0211, 8'd1, 1'b0};
        vecs[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hFF22, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0211, 8'd1, 1'b0};
        vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hFF22, 8'd1, 1'b0};
        vecs[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'd1, 1'b0};
        vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'd1, 1'b0};
        vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'd1, 1'b1};
        vecs[11] = '{1'b1, 16'h0400, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0400, 1'b0, 16'h0000, 8'd1, 1'b1};
        vecs[12] = '{1'b1, 16'h0401, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0401, 1'b0, 16'h0000, 8'd1, 1'b1};
        vecs[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'd1, 1'b1};

        // Asynchronous reset state, before any clock edge
        #2;
        chk("rst_pndng", 32'(pndng), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_tx_full", 32'(tx_full), 32'd0);
        chk("rst_flags", {30'd0, tx_ovf, tx_udf}, 32'd0);
        chk("rst_counters", {16'd0, rx_drop_cnt, rx_miss_cnt}, 32'd0);

        // Inputs held active across an edge while in reset must be ignored
        model_clear();
        step(1'b1, 16'h0299, 1'b1, 1'b1, 16'h0299, 1'b1);
        reset = 1'b1;
        idle();

        // Vector table
        for (int i = 0; i < NV; i++) begin
            step(vecs[i].we, vecs[i].wd, vecs[i].p, vecs[i].ps, vecs[i].dp, vecs[i].re);
            chk($sformatf("vec%0d_pndng", i), 32'(pndng), 32'(vecs[i].e_pndng));
            if (vecs[i].e_pndng) chk($sformatf("vec%0d_D_pop", i), 32'(D_pop), 32'(vecs[i].e_dpop));
            chk($sformatf("vec%0d_rx_valid", i), 32'(rx_valid), 32'(vecs[i].e_rxv));
            if (vecs[i].e_rxv) chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].e_rd));
            chk($sformatf("vec%0d_miss", i), 32'(rx_miss_cnt), 32'(vecs[i].e_miss));
            chk($sformatf("vec%0d_udf", i), 32'(tx_udf), 32'(vecs[i].e_udf));
        end

        // TX overflow: nine writes into a depth-8 FIFO, then drain in order
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 16'h0500 + 16'(i), 1'b0, 1'b0, '0, 1'b0);
            if (i == 7) chk("ovf_full_after_8", 32'(tx_full), 32'd1);
            if (i == 7) chk("ovf_not_yet", 32'(tx_ovf), 32'd0);
        end
        chk("ovf_set", 32'(tx_ovf), 32'd1);
        // Write while full with concurrent pop must still be dropped
        step(1'b1, 16'h05EE, 1'b1, 1'b0, '0, 1'b0);
        chk("ovf_pop_drop_head", 32'(D_pop), 32'h0501);
        chk("ovf_pop_not_full", 32'(tx_full), 32'd0);
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("drain%0d", i), 32'(D_pop), 32'h0500 + 32'(i));
            step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        end
        chk("drain_empty", 32'(pndng), 32'd0);

        // RX full: read-with-push stores, push alone drops
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b0, 1'b1, 16'h0260 + 16'(i), 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 16'h02A0, 1'b1);
        chk("rxfull_rd_drop0", 32'(rx_drop_cnt), 32'd0);
        chk("rxfull_rd_head", 32'(rd_data), 32'h0261);
        step(1'b0, '0, 1'b0, 1'b1, 16'hFFA1, 1'b0);
        chk("rxfull_drop1", 32'(rx_drop_cnt), 32'd1);
        for (int i = 1; i < DEPTH; i++) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        chk("rxfull_tail", 32'(rd_data), 32'h02A0);

        // Underflow, then asynchronous reset with entries queued
        do_reset();
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        chk("udf_set", 32'(tx_udf), 32'd1);
        chk("udf_no_pndng", 32'(pndng), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0700 + 16'(i), 1'b0, 1'b1, 16'h0200, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 16'h0900, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_pndng", 32'(pndng), 32'd0);
        chk("async_rx_valid", 32'(rx_valid), 32'd0);
        chk("async_flags", {30'd0, tx_ovf, tx_udf}, 32'd0);
        chk("async_counters", {16'd0, rx_drop_cnt, rx_miss_cnt}, 32'd0);
        model_clear();
        step(1'b1, 16'h0777, 1'b0, 1'b0, '0, 1'b0);
        reset = 1'b1;
        step(1'b1, 16'h0801, 1'b0, 1'b0, '0, 1'b0);
        chk("post_rst_head", 32'(D_pop), 32'h0801);
        step(1'b1, 16'h0802, 1'b0, 1'b0, '0, 1'b0);

        // Randomized concurrent traffic in phases of varying pressure
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            int unsigned ph = 32'(i) / 2500;
            int unsigned wp = (ph == 0) ? 50 : (ph == 1) ? 85 : (ph == 2) ? 20 : 60;
            int unsigned pp = (ph == 0) ? 50 : (ph == 1) ? 20 : (ph == 2) ? 85 : 60;
            int unsigned rp = (ph == 1) ? 10 : (ph == 2) ? 90 : 50;
            int unsigned sel = $urandom_range(0, 9);
            logic [7:0]  dest = (sel < 4) ? MYID : (sel < 6) ? BCAST : 8'($urandom_range(0, 255));
            step($urandom_range(0, 99) < wp, 16'($urandom), $urandom_range(0, 99) < pp,
                 $urandom_range(0, 99) < 70, {dest, 8'($urandom)}, $urandom_range(0, 99) < rp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_endpoint.md
BUS_ENDPOINT -- requirements
Module: bus_endpoint

Interface
REQ-001 Parameter: pckg_sz, 16, packet width in bits; bits [pckg_sz-1 -: 8] hold the destination ID.
REQ-002 Parameter: depth, 8, entries per FIFO; power of two, at least 2.
REQ-003 Parameter: id, 8'h00, this endpoint's bus address.
REQ-004 Parameter: broadcast, {8{1'b1}}, destination ID accepted by every endpoint.
REQ-005 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-006 Port: reset  in  1  asynchronous, active-low reset.
REQ-007 Port: wr_en  in  1  local request to enqueue wr_data into the TX FIFO.
REQ-008 Port: wr_data  in  pckg_sz  local packet to transmit.
REQ-009 Port: tx_full  out  1  TX FIFO holds depth entries.
REQ-010 Port: pndng  out  1  TX FIFO not empty (request to the bus arbiter).
REQ-011 Port: D_pop  out  pckg_sz  TX FIFO head entry, valid while pndng=1.
REQ-012 Port: pop  in  1  arbiter consumes D_pop.
REQ-013 Port: push  in  1  arbiter delivers D_push this cycle.
REQ-014 Port: D_push  in  pckg_sz  packet delivered by the bus.
REQ-015 Port: rx_valid  out  1  RX FIFO not empty.
REQ-016 Port: rd_data  out  pckg_sz  RX FIFO head entry.
REQ-017 Port: rd_en  in  1  local consumer dequeues rd_data.
REQ-018 Port: tx_ovf  out  1  sticky flag: a write was attempted while the TX FIFO was full.
REQ-019 Port: tx_udf  out  1  sticky flag: pop arrived while the TX FIFO was empty.
REQ-020 Port: rx_drop_cnt  out  8  number of packets dropped because the RX FIFO was full; saturates at 255.
REQ-021 Port: rx_miss_cnt  out  8  number of pushes filtered out by address; saturates at 255.

Function
REQ-022 Both FIFOs SHALL be show-ahead: D_pop and rd_data SHALL equal the head entry combinationally from storage, with no read latency.
REQ-023 TX FIFO write: when wr_en=1 and tx_full=0, the entry SHALL be stored at the clock edge and SHALL appear on pndng/D_pop on the next cycle.
REQ-024 TX FIFO, wr_en=1 while tx_full=1: the data SHALL be dropped, including when pop=1 in the same cycle, and tx_ovf SHALL set.
REQ-025 TX FIFO, pop=1 while pndng=1: the read pointer SHALL advance by one at that edge.
REQ-026 TX FIFO, pop=1 while pndng=0: pointers SHALL be unchanged and tx_udf SHALL set.
REQ-027 TX FIFO, simultaneous write (not full) and valid pop: the occupancy SHALL be unchanged and both pointers SHALL advance.
REQ-028 RX address filter: on push=1, accept the packet only if D_push[pckg_sz-1 -: 8] equals id or broadcast.
REQ-029 RX, push=1 with a non-matching destination: the packet SHALL NOT be stored and rx_miss_cnt SHALL increment.
REQ-030 RX, accepted packet while the RX FIFO is not full: the packet SHALL be stored and rx_valid SHALL assert on the next cycle.
REQ-031 RX, accepted packet while the RX FIFO is full: if rd_en=1 in the same cycle, the packet SHALL be stored; otherwise it SHALL be dropped and rx_drop_cnt SHALL increment.
REQ-032 RX, rd_en=1 while rx_valid=0: ignored, with no state change.
REQ-033 Pointers SHALL be $clog2(depth)+1 bits wide; full/empty SHALL be decided by the MSB difference, with wrap-around modulo 2·depth.
REQ-034 Occupancy SHALL never exceed depth nor go below 0 under any input combination.
REQ-035 Both counters SHALL hold at 8'hFF once reached.

Reset
REQ-036 With reset=0, asynchronously: all pointers SHALL be 0, pndng=0, rx_valid=0, tx_full=0, tx_ovf=0, tx_udf=0, and both counters 0; FIFO storage need not be cleared.
REQ-037 Reset mid-operation SHALL discard all queued packets; the first post-reset write SHALL become the next head entry.
REQ-038 Inputs SHALL be ignored while reset=0; normal operation SHALL begin on the first rising edge after reset=1.

Verification
REQ-039 Directed: id=2, write 16'h02AA then 16'h0355 -> pndng=1 and D_pop=16'h02AA; pop -> D_pop=16'h0355; pop -> pndng=0.
REQ-040 Directed: 9 writes with depth=8 and no pop -> tx_full=1 after the 8th write, tx_ovf=1, 8 entries then drain in order.
REQ-041 Directed: push D_push=16'h0211 (id=2), 16'h0311, 16'hFF22 -> RX FIFO holds 16'h0211 and 16'hFF22; rx_miss_cnt=1.
REQ-042 Directed: fill the RX FIFO, then push a matching packet with rd_en=1 -> stored, rx_drop_cnt=0; repeat with rd_en=0 -> rx_drop_cnt=1.
REQ-043 Directed: pop while empty -> tx_udf=1, pointers unchanged; assert reset=0 with 3 entries queued -> pndng=0 immediately, flags and counters 0.
REQ-044 Directed: random concurrent wr_en/pop/push/rd_en for 10k cycles against a scoreboard -> no loss or reorder beyond the counted drops.
